// File: rtl/decode_bpred.sv
// Direct-mapped BTB branch/jump predictor with ID-stage resolution and recovery.
// IF looks up a prediction; ID trains the table, flags mispredicts and keeps perf counts.
module decode_bpred #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned IDX_BITS  = 4,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned PERF_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     if_pc,
    output logic                 if_pred_taken,
    output logic [WIDTH-1:0]     if_pred_tgt,
    input  logic                 id_valid,
    input  logic                 id_stall,
    input  logic                 id_is_br,
    input  logic                 id_is_jmp,
    input  logic [WIDTH-1:0]     id_pc,
    input  logic [WIDTH-1:0]     id_pc_inc,
    input  logic                 id_pred_taken,
    input  logic [WIDTH-1:0]     id_pred_tgt,
    input  logic                 id_act_taken,
    input  logic [WIDTH-1:0]     id_act_tgt,
    input  logic                 bp_clear,
    output logic                 redirect,
    output logic [WIDTH-1:0]     redirect_pc,
    output logic                 flush,
    output logic [PERF_BITS-1:0] perf_br,
    output logic [PERF_BITS-1:0] perf_misp
);
    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned TAG_W   = WIDTH - IDX_BITS - 1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));

    logic                valid_q [ENTRIES];
    logic [TAG_W-1:0]    tag_q   [ENTRIES];
    logic [WIDTH-1:0]    tgt_q   [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q   [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, id_idx;
    logic [TAG_W-1:0]    if_tag, id_tag;
    logic                if_hit, id_hit;
    logic                res, ctl, misp;
    logic                unused_lsb;

    assign if_idx = if_pc[IDX_BITS:1];
    assign if_tag = if_pc[WIDTH-1:IDX_BITS+1];
    assign id_idx = id_pc[IDX_BITS:1];
    assign id_tag = id_pc[WIDTH-1:IDX_BITS+1];
    assign unused_lsb = if_pc[0] ^ id_pc[0];

    assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign id_hit        = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
    assign if_pred_taken = if_hit & ctr_q[if_idx][CTR_BITS-1];
    assign if_pred_tgt   = if_hit ? tgt_q[if_idx] : '0;

    assign res  = id_valid & ~id_stall & ~rst;
    assign ctl  = id_is_br | id_is_jmp;
    assign misp = res & ((ctl & (id_pred_taken != id_act_taken))
                       | (ctl & id_act_taken & id_pred_taken & (id_pred_tgt != id_act_tgt))
                       | (~ctl & id_pred_taken));

    assign redirect    = misp;
    assign flush       = misp;
    assign redirect_pc = id_act_taken ? id_act_tgt : id_pc_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= CTR_WEAK_NT;
            end
            perf_br   <= '0;
            perf_misp <= '0;
        end else begin
            if (res && ctl && (perf_br != '1))
                perf_br <= perf_br + PERF_BITS'(1);
            if (misp && (perf_misp != '1))
                perf_misp <= perf_misp + PERF_BITS'(1);

            if (bp_clear) begin
                for (int unsigned i = 0; i < ENTRIES; i++)
                    valid_q[i] <= 1'b0;
            end else if (res) begin
                if (ctl) begin
                    if (id_hit) begin
                        if (id_act_taken) begin
                            tgt_q[id_idx] <= id_act_tgt;
                            if (ctr_q[id_idx] != '1)
                                ctr_q[id_idx] <= ctr_q[id_idx] + CTR_BITS'(1);
                        end else if (ctr_q[id_idx] != '0) begin
                            ctr_q[id_idx] <= ctr_q[id_idx] - CTR_BITS'(1);
                        end
                    end else if (id_act_taken) begin
                        valid_q[id_idx] <= 1'b1;
                        tag_q[id_idx]   <= id_tag;
                        tgt_q[id_idx]   <= id_act_tgt;
                        ctr_q[id_idx]   <= id_is_jmp ? '1 : CTR_WEAK_T;
                    end
                end else if (id_hit || id_pred_taken) begin
                    // A non-branch predicted taken names the entry that produced it, even
                    // when its tag no longer matches; drop that entry at the shared index.
                    valid_q[id_idx] <= 1'b0;
                end
            end
        end
    end
endmodule
